uart_tx_buffered: RTL

//  Buffered UART transmitter: counterpart of the UART receive path. Bytes are written into an

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx_buffered.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int C_PARITY_NONE = 0;
    localparam int C_PARITY_EVEN = 1;
    localparam int C_PARITY_ODD  = 2;

    localparam int C_LSB_FIRST = 0;
    localparam int C_MSB_FIRST = 1;

    // Clock cycles per serial bit; integer floor of the ratio.
    function automatic int bit_ticks(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter; pointers carry an extra wrap bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int G_DATA_WIDTH = 8,
    parameter int G_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [G_DATA_WIDTH-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [G_DATA_WIDTH-1:0] o_rd_data,
    output logic                    o_full,
    output logic [G_ADDR_WIDTH:0]   o_level,
    output logic                    o_wr_err
);

    localparam int C_DEPTH = 2 ** G_ADDR_WIDTH;
    localparam int C_PTR_W = G_ADDR_WIDTH + 1;

    logic [G_DATA_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                    wr_err_q, wr_err_d;
    logic                    full;
    logic                    empty;
    logic                    wr_ok;
    logic                    rd_ok;

    always_comb begin
        // Equal low bits with differing wrap bits means the write side has lapped the read side.
        full     = (wr_ptr_q[G_ADDR_WIDTH] != rd_ptr_q[G_ADDR_WIDTH]) &&
                   (wr_ptr_q[G_ADDR_WIDTH-1:0] == rd_ptr_q[G_ADDR_WIDTH-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        wr_ok    = i_wr_en && !full;
        rd_ok    = i_rd_en && !empty;
        wr_ptr_d = wr_ptr_q + C_PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + C_PTR_W'(rd_ok);
        wr_err_d = i_wr_en && full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[G_ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q[G_ADDR_WIDTH-1:0]];
    assign o_full    = full;
    assign o_level   = wr_ptr_q - rd_ptr_q;
    assign o_wr_err  = wr_err_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO plus frame serialiser with configurable parity,
// stop bits, bit order and line polarity.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int G_CLOCK_FREQUENCY   = 50_000_000,
    parameter int G_BAUDRATE          = 115200,
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_STOP_BIT_NUMBER   = 1,
    parameter int G_PARITY            = 0,
    parameter int G_FIRST_BIT         = 0,
    parameter int G_POLARITY          = 1,
    parameter int G_BUFFER_ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic                         i_wr_en,
    input  logic [G_DATA_WIDTH-1:0]      i_wr_data,
    output logic                         o_full,
    output logic [G_BUFFER_ADDR_WIDTH:0] o_level,
    output logic                         o_wr_err,
    output logic                         o_busy,
    output logic                         o_tx_done,
    output logic                         o_tx
);

    localparam int                  C_BIT_TICKS    = bit_ticks(G_CLOCK_FREQUENCY, G_BAUDRATE);
    localparam int                  C_TICK_W       = $clog2(C_BIT_TICKS);
    localparam logic [C_TICK_W-1:0] C_TICK_LAST    = C_TICK_W'(C_BIT_TICKS - 1);
    localparam logic [C_TICK_W-1:0] C_TICK_PRELAST = C_TICK_W'(C_BIT_TICKS - 2);
    localparam logic [3:0]          C_DATA_LAST    = 4'(G_DATA_WIDTH - 1);
    localparam logic [3:0]          C_STOP_LAST    = 4'(G_STOP_BIT_NUMBER - 1);
    localparam logic                C_IDLE_LEVEL   = (G_POLARITY != 0);

    tx_state_t                 state_q, state_d;
    logic [C_TICK_W-1:0]       tick_q, tick_d;
    logic [3:0]                idx_q, idx_d;
    logic [G_DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                      par_q, par_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      pop;
    logic                      tick_end;
    logic [G_DATA_WIDTH-1:0]   shifted;
    logic [G_DATA_WIDTH-1:0]   fifo_data;
    logic [G_BUFFER_ADDR_WIDTH:0] fifo_level;

    function automatic logic line_level(input logic b);
        return C_IDLE_LEVEL ? b : ~b;
    endfunction

    function automatic logic head_bit(input logic [G_DATA_WIDTH-1:0] s);
        return (G_FIRST_BIT == C_MSB_FIRST) ? s[G_DATA_WIDTH-1] : s[0];
    endfunction

    function automatic logic [G_DATA_WIDTH-1:0] advance(input logic [G_DATA_WIDTH-1:0] s);
        return (G_FIRST_BIT == C_MSB_FIRST) ? (s << 1) : (s >> 1);
    endfunction

    uart_tx_fifo #(
        .G_DATA_WIDTH (G_DATA_WIDTH),
        .G_ADDR_WIDTH (G_BUFFER_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (pop),
        .o_rd_data (fifo_data),
        .o_full    (o_full),
        .o_level   (fifo_level),
        .o_wr_err  (o_wr_err)
    );

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        tick_end = (tick_q == C_TICK_LAST);
        shifted  = advance(shift_q);

        if (state_q != IDLE) begin
            tick_d = tick_end ? '0 : tick_q + C_TICK_W'(1);
        end

        // tx_d is always the level of the cycle that follows, so o_tx stays a plain flop.
        case (state_q)
            IDLE: begin
                tx_d = C_IDLE_LEVEL;
                if (i_en && (fifo_level != '0)) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
                    par_d   = (G_PARITY == C_PARITY_ODD) ? ~^fifo_data : ^fifo_data;
                    tick_d  = '0;
                    idx_d   = '0;
                    state_d = START;
                    tx_d    = line_level(1'b0);
                end
            end
            START: begin
                if (tick_end) begin
                    state_d = DATA;
                    tx_d    = line_level(head_bit(shift_q));
                end
            end
            DATA: begin
                if (tick_end) begin
                    if (idx_q == C_DATA_LAST) begin
                        idx_d = '0;
                        if (G_PARITY != C_PARITY_NONE) begin
                            state_d = PARITY;
                            tx_d    = line_level(par_q);
                        end else begin
                            state_d = STOP;
                            tx_d    = line_level(1'b1);
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = shifted;
                        tx_d    = line_level(head_bit(shifted));
                    end
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                    tx_d    = line_level(1'b1);
                end
            end
            STOP: begin
                // Raised one cycle early so the registered pulse lands on the final stop cycle.
                done_d = (idx_q == C_STOP_LAST) && (tick_q == C_TICK_PRELAST);
                if (tick_end) begin
                    if (idx_q == C_STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        tx_d    = C_IDLE_LEVEL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = C_IDLE_LEVEL;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            tx_q    <= C_IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign o_level   = fifo_level;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;
    assign o_tx      = tx_q;

endmodule
